task_pack_echo_slave: RTL
=========================

// Module: task_pack_echo_slave
// PURPOSE
// Task-side slave engine for the task manager's byte-in / word-out task protocol.
// - Receives one test-vector packet of bytes over the task input channel.
// - Returns the bytes packed little-endian into 32-bit words, then one trailer word
//   carrying the byte count, an XOR checksum and an overflow flag.
// - Sits in a task slot of the control top, driven by the task manager like any task_N.
// PARAMETERS
// DATA_WIDTH_IN   8    input byte width; only 8 is supported
// DATA_WIDTH_OUT  32   answer word width; only 32 is supported
// MAX_BYTES       64   byte buffer depth; multiple of 4; bytes beyond it are counted, not stored
// PORTS
// i_clk                            in   1   clock
// i_rst                            in   1   reset, synchronous, active-high
// task_data_request                out  1   slave can accept input bytes
// task_data_valid                  in   1   task_data holds a byte this cycle
// task_data                        in   8   input byte
// task_data_last                   in   1   this byte ends the packet
// task_answer_ready                out  1   task_answer_data holds a valid word
// task_manager_ready               in   1   manager accepts the word this cycle
// task_answer_data                 out  32  answer word
// task_answer_data_last            out  1   current word is the trailer
// task_answer_packet_size_in_bytes out  1   1 on the trailer word, 0 on data words
// BEHAVIOUR
// Clock and reset:
// - Clock i_clk; reset i_rst, synchronous, active-high.
// - Reset values: all outputs 0; state RX; counters, checksum and overflow cleared.
// - The buffer is not cleared on reset.
// FSM:
// - RX: task_data_request=1 from the first cycle after reset deasserts.
//   - A byte is accepted on every cycle with task_data_valid=1.
//   - byte i goes to buf[i] while i<MAX_BYTES; otherwise it is dropped and ovf<=1.
//   - cnt (15 bits) increments, saturating at 32767; chk <= chk ^ byte for every accepted byte.
//   - An accepted byte with task_data_last=1 -> TX_DATA, request=0 on the next cycle.
// - TX_DATA: emits W=ceil(min(cnt,MAX_BYTES)/4) words.
//   - word k = {buf[4k+3],buf[4k+2],buf[4k+1],buf[4k]}; positions >= stored bytes read as 0.
//   - task_answer_ready=1; a word transfers when task_answer_ready && task_manager_ready.
//   - The next word is presented the following cycle, giving 1 word/cycle under constant ready.
//   - After word W-1 transfers -> TX_TRL.
// - TX_TRL: task_answer_data = {8'hA5, chk[7:0], ovf, cnt[14:0]}.
//   - task_answer_data_last=1 and packet_size bit=1.
//   - On transfer -> RX: cnt, chk and ovf cleared; request=1 on the next cycle.
// Handshake and timing:
// - First answer word is valid 1 cycle after the last byte is accepted.
// - While ready=1 and task_manager_ready=0, data, last and size hold stable.
// - ready stays 1 until transfer; no bubbles and no withdrawal.
// - task_data_valid outside RX is ignored (no count, no checksum update).
// Boundary cases:
// - cnt=MAX_BYTES exactly: W=MAX_BYTES/4 and ovf=0.
// - Byte MAX_BYTES+1 sets ovf; W stays MAX_BYTES/4.
// - A packet with a single byte is legal: W=1.
// - Reset in any state returns to RX with outputs 0 on the next cycle; a partial packet is discarded.
// TESTING
// - Bytes 01,02,03,04,05 (last on 05), manager ready=1
//   -> 0x04030201, 0x00000005, trailer 0xA5010005 with last=1; 3 consecutive cycles.
// - Same packet, task_manager_ready toggling 0/1 per cycle -> same 3 words, each held stable while ready=0.
// - Single byte 0xFF with last -> 0x000000FF, then trailer 0xA5FF0001.
// - 70 bytes of 0x00 with MAX_BYTES=64
//   -> 16 words 0x00000000, trailer 0xA5008046 (ovf=1, cnt=70).
// - Valid pulses during TX_DATA -> ignored; the next packet 0x10 returns 0x00000010, trailer 0xA5100001.
// - i_rst asserted in TX_DATA after 1 word -> outputs 0 next cycle, request=1 afterwards;
//   the new packet is answered correctly.

Source files
------------

// File: rtl/task_pack_echo_slave.sv
// -----------------------------------------------------------------------------
// task_pack_echo_slave
//
// Task-side slave for the byte-in / word-out task protocol. It collects one
// packet of bytes, then answers with the bytes packed little-endian into
// 32-bit words followed by one trailer word {8'hA5, xor checksum, overflow,
// 15-bit byte count}.
//
// Ports
//   i_clk                            clock
//   i_rst                            synchronous reset, active-high
//   task_data_request                slave accepts input bytes
//   task_data_valid                  task_data holds a byte this cycle
//   task_data                        input byte
//   task_data_last                   byte ends the packet
//   task_answer_ready                task_answer_data holds a valid word
//   task_manager_ready               manager takes the word this cycle
//   task_answer_data                 answer word
//   task_answer_data_last            current word is the trailer
//   task_answer_packet_size_in_bytes 1 on the trailer word, 0 on data words
// -----------------------------------------------------------------------------
module task_pack_echo_slave #(
   parameter int DATA_WIDTH_IN  = 8,
   parameter int DATA_WIDTH_OUT = 32,
   parameter int MAX_BYTES      = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   output logic                      task_data_request,
   input  logic                      task_data_valid,
   input  logic [DATA_WIDTH_IN-1:0]  task_data,
   input  logic                      task_data_last,
   output logic                      task_answer_ready,
   input  logic                      task_manager_ready,
   output logic [DATA_WIDTH_OUT-1:0] task_answer_data,
   output logic                      task_answer_data_last,
   output logic                      task_answer_packet_size_in_bytes
);

   localparam int                CNT_W   = 15;
   localparam int                AW      = $clog2(MAX_BYTES);
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0]  CNT_SAT = '1;

   typedef enum logic [1:0] {
      ST_RX      = 2'd0,
      ST_TX_DATA = 2'd1,
      ST_TX_TRL  = 2'd2
   } state_t;

   state_t                    state, state_nxt;
   logic                      rst_hold;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [7:0]                chk, chk_nxt;
   logic                      ovf, ovf_nxt;
   logic [CNT_W-1:0]          widx, widx_nxt;
   logic [CNT_W-1:0]          stored;
   logic [CNT_W-1:0]          last_widx;
   logic                      accept;
   logic                      store;
   logic [DATA_WIDTH_OUT-1:0] word;
   logic [DATA_WIDTH_OUT-1:0] trailer;

   // Byte buffer: data only, deliberately left out of reset.
   logic [DATA_WIDTH_IN-1:0]  byte_mem [MAX_BYTES];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + CNT_W'(1);
   endfunction

   // rst_hold keeps the request low for the whole reset and releases it on
   // the first cycle after i_rst deasserts.
   assign accept = (state == ST_RX) && !rst_hold && task_data_valid;
   assign store  = accept && (cnt < MAX_CNT);

   // Number of bytes actually held in the buffer and the index of the last
   // data word; stored is at least 1 whenever the FSM is transmitting.
   assign stored    = (cnt < MAX_CNT) ? cnt : MAX_CNT;
   assign last_widx = ((stored + CNT_W'(3)) >> 2) - CNT_W'(1);

   assign trailer = {8'hA5, chk, ovf, cnt};

   // Little-endian word assembly; byte positions past the stored bytes
   // read as zero so stale buffer contents never leak into the answer.
   always_comb begin
      logic [CNT_W-1:0] pos;
      word = '0;
      pos  = '0;
      for (int j = 0; j < 4; j++) begin
         pos = {widx[CNT_W-3:0], 2'(j)};
         if (pos < stored)
            word[j*DATA_WIDTH_IN +: DATA_WIDTH_IN] = byte_mem[pos[AW-1:0]];
      end
   end

   always_ff @(posedge i_clk) begin
      if (store)
         byte_mem[cnt[AW-1:0]] <= task_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_RX;
         rst_hold <= 1'b1;
         cnt      <= '0;
         chk      <= '0;
         ovf      <= 1'b0;
         widx     <= '0;
      end else begin
         state    <= state_nxt;
         rst_hold <= 1'b0;
         cnt      <= cnt_nxt;
         chk      <= chk_nxt;
         ovf      <= ovf_nxt;
         widx     <= widx_nxt;
      end
   end

   always_comb begin
      state_nxt                        = state;
      cnt_nxt                          = cnt;
      chk_nxt                          = chk;
      ovf_nxt                          = ovf;
      widx_nxt                         = widx;
      task_data_request                = 1'b0;
      task_answer_ready                = 1'b0;
      task_answer_data                 = '0;
      task_answer_data_last            = 1'b0;
      task_answer_packet_size_in_bytes = 1'b0;

      case (state)
         ST_RX: begin
            task_data_request = !rst_hold;
            if (accept) begin
               cnt_nxt = sat_inc(cnt);
               chk_nxt = chk ^ task_data;
               // Bytes past the buffer are still counted and checksummed.
               if (cnt >= MAX_CNT)
                  ovf_nxt = 1'b1;
               if (task_data_last) begin
                  state_nxt = ST_TX_DATA;
                  widx_nxt  = '0;
               end
            end
         end

         ST_TX_DATA: begin
            task_answer_ready = 1'b1;
            task_answer_data  = word;
            if (task_manager_ready) begin
               if (widx == last_widx)
                  state_nxt = ST_TX_TRL;
               else
                  widx_nxt = widx + CNT_W'(1);
            end
         end

         ST_TX_TRL: begin
            task_answer_ready                = 1'b1;
            task_answer_data                 = trailer;
            task_answer_data_last            = 1'b1;
            task_answer_packet_size_in_bytes = 1'b1;
            if (task_manager_ready) begin
               state_nxt = ST_RX;
               cnt_nxt   = '0;
               chk_nxt   = '0;
               ovf_nxt   = 1'b0;
               widx_nxt  = '0;
            end
         end

         default: begin
            state_nxt = ST_RX;
         end
      endcase
   end

endmodule
